// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. The data side wins by default,
// and a starvation counter forces a fetch through. The optional response watchdog is enabled by MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_wen,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_mask,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_req,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int SC_W   = $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q;
  logic [SC_W-1:0]     starve_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   mask_q;
  logic                wen_q;
  logic                any_req;
  logic                if_forced;
  logic                d_wins;
  logic                tmo_fire;

  assign any_req   = i_if_req | i_d_req;
  assign if_forced = i_if_req && (starve_q == STARVE_MAX);
  assign d_wins    = i_d_req && !if_forced;

  assign o_mem_wen   = wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;

  // The winner's payload is captured at the decision, so the port stays stable under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        if (d_wins) begin
          owner_q  <= OWN_D;
          addr_q   <= i_d_addr;
          wdata_q  <= i_d_wdata;
          mask_q   <= i_d_mask;
          wen_q    <= i_d_wen;
          starve_q <= i_if_req ? starve_q + 1'b1 : '0;
        end else begin
          owner_q  <= OWN_IF;
          addr_q   <= i_if_addr;
          wdata_q  <= '0;
          mask_q   <= '1;
          wen_q    <= 1'b0;
          starve_q <= '0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    o_mem_req   = 1'b0;
    o_if_gnt    = 1'b0;
    o_d_gnt     = 1'b0;
    o_if_rvalid = 1'b0;
    o_d_rvalid  = 1'b0;
    o_if_rdata  = '0;
    o_d_rdata   = '0;
    o_err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          state_d = WAIT;
          if (owner_q == OWN_D) o_d_gnt = 1'b1;
          else                  o_if_gnt = 1'b1;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            o_d_rvalid = 1'b1;
            o_d_rdata  = i_mem_rdata;
          end else begin
            o_if_rvalid = 1'b1;
            o_if_rdata  = i_mem_rdata;
          end
        end else if (tmo_fire) begin
          // A lost response is reported as a completion with zero data, which keeps the pipeline moving.
          state_d = IDLE;
          o_err   = 1'b1;
          if (owner_q == OWN_D) o_d_rvalid = 1'b1;
          else                  o_if_rvalid = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [TW-1:0] tmo_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               tmo_q <= '0;
    else if (state_q != WAIT)   tmo_q <= '0;
    else                        tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_fire = (state_q == WAIT) && (tmo_q == TMO_MAX);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_fire       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It covers reset, fetch and store/load paths, priority and starvation,
// backpressure, and, with MEM_ARB_TIMEOUT_EN, the response watchdog.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_wen;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_mask;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic exp_d_win [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .TIMEOUT(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .i_d_mask(d_mask),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dr,
                               input logic dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic [3:0] dm);
    if_req  = ifr;
    if_addr = ifa;
    d_req   = dr;
    d_wen   = dw;
    d_addr  = da;
    d_wdata = dd;
    d_mask  = dm;
    #1;
  endtask

  task automatic applyMem(input logic rdy, input logic rv, input logic [31:0] rd);
    mem_ready  = rdy;
    mem_rvalid = rv;
    mem_rdata  = rd;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyMem(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req",  64'(mem_req),  64'h0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0);
    checkOutput("rst_mem_mask", 64'(mem_mask), 64'h0);
    checkOutput("rst_gnts",     64'({if_gnt, d_gnt}), 64'h0);
    checkOutput("rst_rvalids",  64'({if_rvalid, d_rvalid}), 64'h0);
    checkOutput("rst_err",      64'(err), 64'h0);
    rst_n = 1'b1;
    next_cycle();

    // Single fetch, response three cycles after the grant
    applyMem(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("fetch_n_req", 64'(mem_req), 64'h0);
    next_cycle();
    checkOutput("fetch_req",  64'(mem_req),  64'h1);
    checkOutput("fetch_gnt",  64'({if_gnt, d_gnt}), 64'h2);
    checkOutput("fetch_addr", 64'(mem_addr), 64'h100);
    checkOutput("fetch_wen",  64'(mem_wen),  64'h0);
    checkOutput("fetch_mask", 64'(mem_mask), 64'hF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    checkOutput("fetch_wait_req",    64'(mem_req),   64'h0);
    checkOutput("fetch_wait_rvalid", 64'(if_rvalid), 64'h0);
    next_cycle();
    next_cycle();
    applyMem(1'b1, 1'b1, 32'hDEADBEEF);
    checkOutput("fetch_rvalid",  64'({if_rvalid, d_rvalid}), 64'h2);
    checkOutput("fetch_rdata",   64'(if_rdata), 64'hDEADBEEF);
    next_cycle();
    applyMem(1'b1, 1'b0, 32'h0);
    checkOutput("fetch_back_idle", 64'(mem_req), 64'h0);

    // Simultaneous requests: the store goes first, then the fetch
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b0011);
    next_cycle();
    checkOutput("sim_d_gnt", 64'({if_gnt, d_gnt}), 64'h1);
    checkOutput("sim_d_wen",   64'(mem_wen),   64'h1);
    checkOutput("sim_d_mask",  64'(mem_mask),  64'h3);
    checkOutput("sim_d_addr",  64'(mem_addr),  64'h200);
    checkOutput("sim_d_wdata", 64'(mem_wdata), 64'hCAFEF00D);
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    applyMem(1'b1, 1'b1, 32'h0);
    checkOutput("sim_d_done", 64'({if_rvalid, d_rvalid}), 64'h1);
    next_cycle();
    applyMem(1'b1, 1'b0, 32'h0);
    next_cycle();
    checkOutput("sim_if_gnt",  64'({if_gnt, d_gnt}), 64'h2);
    checkOutput("sim_if_wen",  64'(mem_wen),  64'h0);
    checkOutput("sim_if_mask", 64'(mem_mask), 64'hF);
    checkOutput("sim_if_addr", 64'(mem_addr), 64'h104);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    applyMem(1'b1, 1'b1, 32'h13579BDF);
    checkOutput("sim_if_rdata", 64'(if_rdata), 64'h13579BDF);
    next_cycle();
    applyMem(1'b1, 1'b0, 32'h0);

    // Both sides request continuously: four data wins, then a forced fetch
    applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 32'h20C, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      checkOutput($sformatf("starve_gnt%0d", i), 64'({if_gnt, d_gnt}),
                  exp_d_win[i] ? 64'h1 : 64'h2);
      next_cycle();
      applyMem(1'b1, 1'b1, 32'h0);
      next_cycle();
      applyMem(1'b1, 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Backpressure in ISSUE; the request is dropped and its inputs are scrambled after latching
    applyMem(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h12345678, 4'b1100);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'hFFF, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_req%0d", i),   64'(mem_req),   64'h1);
      checkOutput($sformatf("bp_addr%0d", i),  64'(mem_addr),  64'h300);
      checkOutput($sformatf("bp_wdata%0d", i), 64'(mem_wdata), 64'h12345678);
      checkOutput($sformatf("bp_gnt%0d", i),   64'({if_gnt, d_gnt}), 64'h0);
      next_cycle();
    end
    applyMem(1'b1, 1'b0, 32'h0);
    checkOutput("bp_gnt_ready", 64'({if_gnt, d_gnt}), 64'h1);
    checkOutput("bp_mask",      64'(mem_mask), 64'hC);
    next_cycle();
    applyMem(1'b1, 1'b1, 32'hFFFF);
    checkOutput("bp_store_done", 64'({if_rvalid, d_rvalid}), 64'h1);
    next_cycle();
    applyMem(1'b1, 1'b0, 32'h0);
    applyMem(1'b1, 1'b1, 32'h55);
    checkOutput("stray_rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);
    checkOutput("stray_rdata",  64'(if_rdata), 64'h0);
    next_cycle();
    applyMem(1'b1, 1'b0, 32'h0);
    checkOutput("stray_no_issue", 64'(mem_req), 64'h0);

    // Reset in the middle of WAIT clears the outputs at once
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    checkOutput("rstw_gnt", 64'({if_gnt, d_gnt}), 64'h2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    applyMem(1'b1, 1'b1, 32'h77);
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);
    checkOutput("rstw_rdata",  64'(if_rdata), 64'h0);
    checkOutput("rstw_addr",   64'(mem_addr), 64'h0);
    checkOutput("rstw_mask",   64'(mem_mask), 64'h0);
    applyMem(1'b1, 1'b0, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    next_cycle();
    checkOutput("post_rst_gnt",  64'({if_gnt, d_gnt}), 64'h1);
    checkOutput("post_rst_addr", 64'(mem_addr), 64'h500);
    checkOutput("post_rst_wen",  64'(mem_wen),  64'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    applyMem(1'b1, 1'b1, 32'hA5A5A5A5);
    checkOutput("post_rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'h1);
    checkOutput("post_rst_rdata",  64'(d_rdata), 64'hA5A5A5A5);
    checkOutput("post_rst_err",    64'(err), 64'h0);
    next_cycle();
    applyMem(1'b1, 1'b0, 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Missing response: the watchdog fires eight cycles after WAIT entry
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    next_cycle();
    checkOutput("tmo_gnt", 64'({if_gnt, d_gnt}), 64'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    repeat (7) next_cycle();
    checkOutput("tmo_early_err",    64'(err), 64'h0);
    checkOutput("tmo_early_rvalid", 64'(d_rvalid), 64'h0);
    next_cycle();
    checkOutput("tmo_err",    64'(err), 64'h1);
    checkOutput("tmo_rvalid", 64'({if_rvalid, d_rvalid}), 64'h1);
    checkOutput("tmo_rdata",  64'(d_rdata), 64'h0);
    next_cycle();
    checkOutput("tmo_err_clear", 64'(err), 64'h0);
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    checkOutput("tmo_next_gnt",  64'({if_gnt, d_gnt}), 64'h2);
    checkOutput("tmo_next_addr", 64'(mem_addr), 64'h700);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    applyMem(1'b1, 1'b1, 32'h1);
    checkOutput("tmo_next_rdata", 64'(if_rdata), 64'h1);
    next_cycle();
    applyMem(1'b1, 1'b0, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
